// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, control-field encodings and the bundled
// control word carried down the pipeline.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;
   localparam logic [1:0] ALUOP_OR    = 2'd3;

   localparam logic [1:0] REGDST_RT = 2'd0;
   localparam logic [1:0] REGDST_RD = 2'd1;
   localparam logic [1:0] REGDST_RA = 2'd2;

   localparam logic [1:0] MEMTOREG_ALU = 2'd0;
   localparam logic [1:0] MEMTOREG_MEM = 2'd1;
   localparam logic [1:0] MEMTOREG_PC4 = 2'd2;

   typedef struct packed {
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic [1:0] alu_op;
      logic       alu_src;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load currently in EX is about to write.
module load_use_detect #(
   parameter int REG_W = 5
) (
   input  logic             i_ex_mem_read,
   input  logic [REG_W-1:0] i_ex_rt,
   input  logic [REG_W-1:0] i_id_rs,
   input  logic [REG_W-1:0] i_id_rt,
   input  logic             i_id_alu_src,
   input  logic             i_id_mem_write,
   output logic             o_hazard
);

   logic w_rt_is_src;
   logic w_rs_match;
   logic w_rt_match;

   // rt is a source for R-type/beq (register operand) and for sw (store data)
   assign w_rt_is_src = ~i_id_alu_src | i_id_mem_write;
   assign w_rs_match  = (i_ex_rt == i_id_rs);
   assign w_rt_match  = (i_ex_rt == i_id_rt) & w_rt_is_src;
   assign o_hazard    = i_ex_mem_read & (i_ex_rt != '0) & (w_rs_match | w_rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush squash.
// Load-use detection is built only when HAZARD_DETECT_EN is defined.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Flush,
   input  logic [1:0]        ID_RegDst,
   input  logic [1:0]        ID_MemtoReg,
   input  logic [1:0]        ID_ALUOp,
   input  logic              ID_ALUSrc,
   input  logic              ID_RegWrite,
   input  logic              ID_MemRead,
   input  logic              ID_MemWrite,
   input  logic              ID_Branch,
   input  logic              ID_jump,
   input  logic [DATA_W-1:0] ID_ReadData1,
   input  logic [DATA_W-1:0] ID_ReadData2,
   input  logic [DATA_W-1:0] ID_Imm,
   input  logic [DATA_W-1:0] ID_PC4,
   input  logic [REG_W-1:0]  ID_Rs,
   input  logic [REG_W-1:0]  ID_Rt,
   input  logic [REG_W-1:0]  ID_Rd,
   output logic [1:0]        EX_RegDst,
   output logic [1:0]        EX_MemtoReg,
   output logic [1:0]        EX_ALUOp,
   output logic              EX_ALUSrc,
   output logic              EX_RegWrite,
   output logic              EX_MemRead,
   output logic              EX_MemWrite,
   output logic              EX_Branch,
   output logic              EX_jump,
   output logic [DATA_W-1:0] EX_ReadData1,
   output logic [DATA_W-1:0] EX_ReadData2,
   output logic [DATA_W-1:0] EX_Imm,
   output logic [DATA_W-1:0] EX_PC4,
   output logic [REG_W-1:0]  EX_Rs,
   output logic [REG_W-1:0]  EX_Rt,
   output logic [REG_W-1:0]  EX_Rd,
   output logic              EX_Valid,
   output logic              Stall
);

   ctrl_t             r_ctrl;
   logic              r_valid;
   logic [DATA_W-1:0] r_rd1, r_rd2, r_imm, r_pc4;
   logic [REG_W-1:0]  r_rs, r_rt, r_rd;

   ctrl_t             w_ctrl_in;
   logic              w_hazard;
   logic              w_bubble;

`ifdef HAZARD_DETECT_EN
   load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
      .i_ex_mem_read  (r_ctrl.mem_read),
      .i_ex_rt        (r_rt),
      .i_id_rs        (ID_Rs),
      .i_id_rt        (ID_Rt),
      .i_id_alu_src   (ID_ALUSrc),
      .i_id_mem_write (ID_MemWrite),
      .o_hazard       (w_hazard)
   );
`else
   assign w_hazard = 1'b0;
`endif

   assign Stall    = w_hazard & ~Flush;
   assign w_bubble = rst | Flush | w_hazard;

   // State-changing bits only count as asserted on a clean 1; X/Z must not
   // turn into a spurious write, branch or jump downstream.
   always_comb begin
      w_ctrl_in            = CTRL_BUBBLE;
      w_ctrl_in.reg_dst    = ID_RegDst;
      w_ctrl_in.mem_to_reg = ID_MemtoReg;
      w_ctrl_in.alu_op     = ID_ALUOp;
      w_ctrl_in.alu_src    = ID_ALUSrc;
      w_ctrl_in.reg_write  = (ID_RegWrite === 1'b1);
      w_ctrl_in.mem_read   = (ID_MemRead  === 1'b1);
      w_ctrl_in.mem_write  = (ID_MemWrite === 1'b1);
      w_ctrl_in.branch     = (ID_Branch   === 1'b1);
      w_ctrl_in.jump       = (ID_jump     === 1'b1);
   end

   always_ff @(posedge clk) begin
      if (w_bubble) begin
         r_ctrl  <= CTRL_BUBBLE;
         r_valid <= 1'b0;
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_imm   <= '0;
         r_pc4   <= '0;
         r_rs    <= '0;
         r_rt    <= '0;
         r_rd    <= '0;
      end else begin
         r_ctrl  <= w_ctrl_in;
         r_valid <= 1'b1;
         r_rd1   <= ID_ReadData1;
         r_rd2   <= ID_ReadData2;
         r_imm   <= ID_Imm;
         r_pc4   <= ID_PC4;
         r_rs    <= ID_Rs;
         r_rt    <= ID_Rt;
         r_rd    <= ID_Rd;
      end
   end

   assign EX_RegDst    = r_ctrl.reg_dst;
   assign EX_MemtoReg  = r_ctrl.mem_to_reg;
   assign EX_ALUOp     = r_ctrl.alu_op;
   assign EX_ALUSrc    = r_ctrl.alu_src;
   assign EX_RegWrite  = r_ctrl.reg_write;
   assign EX_MemRead   = r_ctrl.mem_read;
   assign EX_MemWrite  = r_ctrl.mem_write;
   assign EX_Branch    = r_ctrl.branch;
   assign EX_jump      = r_ctrl.jump;
   assign EX_ReadData1 = r_rd1;
   assign EX_ReadData2 = r_rd2;
   assign EX_Imm       = r_imm;
   assign EX_PC4       = r_pc4;
   assign EX_Rs        = r_rs;
   assign EX_Rt        = r_rt;
   assign EX_Rd        = r_rd;
   assign EX_Valid     = r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage; each row is one clock of ID inputs with
// hand-derived hazard/bubble expectations for both build configurations.
module tb_id_ex_stage;

`ifdef HAZARD_DETECT_EN
   localparam bit HD = 1'b1;
`else
   localparam bit HD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, Flush;
   logic [1:0]  ID_RegDst, ID_MemtoReg, ID_ALUOp;
   logic        ID_ALUSrc, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_Branch, ID_jump;
   logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC4;
   logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
   logic [1:0]  EX_RegDst, EX_MemtoReg, EX_ALUOp;
   logic        EX_ALUSrc, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Branch, EX_jump;
   logic [31:0] EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC4;
   logic [4:0]  EX_Rs, EX_Rt, EX_Rd;
   logic        EX_Valid, Stall;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
      .clk(clk), .rst(rst), .Flush(Flush),
      .ID_RegDst(ID_RegDst), .ID_MemtoReg(ID_MemtoReg), .ID_ALUOp(ID_ALUOp),
      .ID_ALUSrc(ID_ALUSrc), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
      .ID_MemWrite(ID_MemWrite), .ID_Branch(ID_Branch), .ID_jump(ID_jump),
      .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
      .ID_PC4(ID_PC4), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
      .EX_RegDst(EX_RegDst), .EX_MemtoReg(EX_MemtoReg), .EX_ALUOp(EX_ALUOp),
      .EX_ALUSrc(EX_ALUSrc), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
      .EX_MemWrite(EX_MemWrite), .EX_Branch(EX_Branch), .EX_jump(EX_jump),
      .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm),
      .EX_PC4(EX_PC4), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
      .EX_Valid(EX_Valid), .Stall(Stall)
   );

   // ctrl word: {RegDst[1:0], MemtoReg[1:0], ALUOp[1:0], ALUSrc, RegWrite, MemRead, MemWrite, Branch, jump}
   typedef struct {
      string       name;
      logic        rst;
      logic        flush;
      logic [11:0] ctrl;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rd1, rd2, imm, pc4;
      bit          hz;
      bit          chk_stall;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs[NV];
   int   checks = 0;
   int   failures = 0;

   function automatic logic [11:0] c(input logic [1:0] dst, input logic [1:0] m2r,
                                     input logic [1:0] aop, input logic src, input logic rw,
                                     input logic mr, input logic mw, input logic br,
                                     input logic jp);
      return {dst, m2r, aop, src, rw, mr, mw, br, jp};
   endfunction

   task automatic setv(input int i, input string nm, input logic r, input logic f,
                       input logic [11:0] ct, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rd1, input bit hz,
                       input bit cs);
      vecs[i].name = nm; vecs[i].rst = r; vecs[i].flush = f; vecs[i].ctrl = ct;
      vecs[i].rs = rs; vecs[i].rt = rt; vecs[i].rd = rd; vecs[i].rd1 = rd1;
      vecs[i].rd2 = 32'hA500_0000 + 32'(i);
      vecs[i].imm = 32'hFFFF_FF00 | 32'(i);
      vecs[i].pc4 = 32'h0040_0000 + 32'(4 * i);
      vecs[i].hz = hz; vecs[i].chk_stall = cs;
   endtask

   task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   logic [11:0]  ex_ctrl, exp_ctrl, in_ctrl;
   logic [142:0] ex_data, exp_data;
   logic         bubble, exp_stall;

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ctrl words for the instruction classes used below
      logic [11:0] RT, LW, SW, ADDI, JALX;
      RT   = c(2'd1, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      LW   = c(2'd0, 2'd1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      SW   = c(2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      ADDI = c(2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      JALX = c(2'd2, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'bx, 1'b1);

      //       idx name           rst   flush ctrl  rs     rt     rd     rd1            hz  chkStall
      setv( 0, "reset0",        1'b1, 1'b0, LW,   5'd7,  5'd8,  5'd1,  32'hDEAD_BEEF, 0, 0);
      setv( 1, "reset1",        1'b1, 1'b0, LW,   5'd7,  5'd8,  5'd1,  32'hCAFE_F00D, 0, 1);
      setv( 2, "rtype_pass",    1'b0, 1'b0, RT,   5'd3,  5'd4,  5'd5,  32'h0000_0011, 0, 1);
      setv( 3, "lw_rt8",        1'b0, 1'b0, LW,   5'd3,  5'd8,  5'd0,  32'h0000_1000, 0, 1);
      setv( 4, "add_use8",      1'b0, 1'b0, RT,   5'd8,  5'd6,  5'd7,  32'h0000_0088, 1, 1);
      setv( 5, "add_use8_held", 1'b0, 1'b0, RT,   5'd8,  5'd6,  5'd7,  32'h0000_0089, 0, 1);
      setv( 6, "lw_rt0",        1'b0, 1'b0, LW,   5'd1,  5'd0,  5'd0,  32'h0000_2000, 0, 1);
      setv( 7, "use_zero",      1'b0, 1'b0, RT,   5'd0,  5'd0,  5'd2,  32'h0000_0000, 0, 1);
      setv( 8, "lw_rt9",        1'b0, 1'b0, LW,   5'd2,  5'd9,  5'd0,  32'h0000_3000, 0, 1);
      setv( 9, "addi_dst9",     1'b0, 1'b0, ADDI, 5'd1,  5'd9,  5'd0,  32'h0000_0001, 0, 1);
      setv(10, "lw_rt10",       1'b0, 1'b0, LW,   5'd2,  5'd10, 5'd0,  32'h0000_4000, 0, 1);
      setv(11, "sw_data10",     1'b0, 1'b0, SW,   5'd4,  5'd10, 5'd0,  32'h0000_0044, 1, 1);
      setv(12, "sw_held",       1'b0, 1'b0, SW,   5'd4,  5'd10, 5'd0,  32'h0000_0045, 0, 1);
      setv(13, "lw_rt11",       1'b0, 1'b0, LW,   5'd2,  5'd11, 5'd0,  32'h0000_5000, 0, 1);
      setv(14, "lw_b2b_use11",  1'b0, 1'b0, LW,   5'd11, 5'd12, 5'd0,  32'h0000_6000, 1, 1);
      setv(15, "lw_b2b_held",   1'b0, 1'b0, LW,   5'd11, 5'd12, 5'd0,  32'h0000_6001, 0, 1);
      setv(16, "flush_on_hz",   1'b0, 1'b1, RT,   5'd12, 5'd3,  5'd4,  32'h0000_0077, 1, 1);
      setv(17, "flush_sw",      1'b0, 1'b1, SW,   5'd4,  5'd5,  5'd0,  32'h0000_0055, 0, 1);
      setv(18, "jal_sanitise",  1'b0, 1'b0, JALX, 5'd0,  5'd0,  5'd31, 32'h0000_0000, 0, 1);
      setv(19, "lw_rt13",       1'b0, 1'b0, LW,   5'd2,  5'd13, 5'd0,  32'h0000_7000, 0, 1);
      setv(20, "rst_mid_stall", 1'b1, 1'b0, RT,   5'd13, 5'd1,  5'd2,  32'h0000_0013, 1, 1);
      setv(21, "after_rst",     1'b0, 1'b0, RT,   5'd13, 5'd1,  5'd2,  32'h0000_0014, 0, 1);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst          = vecs[i].rst;
         Flush        = vecs[i].flush;
         {ID_RegDst, ID_MemtoReg, ID_ALUOp, ID_ALUSrc, ID_RegWrite, ID_MemRead,
          ID_MemWrite, ID_Branch, ID_jump} = vecs[i].ctrl;
         ID_Rs        = vecs[i].rs;
         ID_Rt        = vecs[i].rt;
         ID_Rd        = vecs[i].rd;
         ID_ReadData1 = vecs[i].rd1;
         ID_ReadData2 = vecs[i].rd2;
         ID_Imm       = vecs[i].imm;
         ID_PC4       = vecs[i].pc4;
         #1;
         exp_stall = HD && vecs[i].hz && !vecs[i].flush;
         if (vecs[i].chk_stall)
            check({vecs[i].name, ".Stall"}, {191'd0, Stall}, {191'd0, exp_stall});

         bubble = vecs[i].rst || vecs[i].flush || (HD && vecs[i].hz);
         in_ctrl = vecs[i].ctrl;
         if (bubble) begin
            exp_ctrl = '0;
            exp_data = '0;
         end else begin
            exp_ctrl = {in_ctrl[11:5], in_ctrl[4] === 1'b1, in_ctrl[3] === 1'b1,
                        in_ctrl[2] === 1'b1, in_ctrl[1] === 1'b1, in_ctrl[0] === 1'b1};
            exp_data = {vecs[i].rd1, vecs[i].rd2, vecs[i].imm, vecs[i].pc4,
                        vecs[i].rs, vecs[i].rt, vecs[i].rd};
         end

         @(posedge clk);
         #1;
         ex_ctrl = {EX_RegDst, EX_MemtoReg, EX_ALUOp, EX_ALUSrc, EX_RegWrite, EX_MemRead,
                    EX_MemWrite, EX_Branch, EX_jump};
         ex_data = {EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC4, EX_Rs, EX_Rt, EX_Rd};
         check({vecs[i].name, ".EX_Valid"}, {191'd0, EX_Valid}, {191'd0, !bubble});
         check({vecs[i].name, ".EX_ctrl"}, {180'd0, ex_ctrl}, {180'd0, exp_ctrl});
         check({vecs[i].name, ".EX_data"}, {49'd0, ex_data}, {49'd0, exp_data});
      end

      // Explicit spot checks for the corner cases named in the plan.
      @(negedge clk);
      rst = 1'b0; Flush = 1'b0;
      {ID_RegDst, ID_MemtoReg, ID_ALUOp, ID_ALUSrc, ID_RegWrite, ID_MemRead,
       ID_MemWrite, ID_Branch, ID_jump} = JALX;
      @(posedge clk);
      #1;
      check("jal.EX_Branch",   {191'd0, EX_Branch},   {191'd0, 1'b0});
      check("jal.EX_jump",     {191'd0, EX_jump},     {191'd0, 1'b1});
      check("jal.EX_RegDst",   {190'd0, EX_RegDst},   {190'd0, 2'd2});
      check("jal.EX_MemtoReg", {190'd0, EX_MemtoReg}, {190'd0, 2'd2});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
